// File: rtl/cpu_bus_responder.sv
// Target end of the CPU address/data bus: serves reads from a small aliased RAM
// window on the T1..T4 schedule, commits writes at T4 and logs them in a FIFO.
module cpu_bus_responder #(
  parameter int ADR_BITS  = 4,
  parameter int LOG_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [15:0]                  adr,
  input  logic                         rd,
  input  logic                         wr,
  input  logic [7:0]                   dout,
  output logic [7:0]                   din,
  output logic [1:0]                   tphase,
  output logic [7:0]                   mcyc,
  input  logic                         init_we,
  input  logic [ADR_BITS-1:0]          init_adr,
  input  logic [7:0]                   init_data,
  output logic                         log_valid,
  output logic [15:0]                  log_adr,
  output logic [7:0]                   log_data,
  input  logic                         log_pop,
  output logic [$clog2(LOG_DEPTH):0]   log_count,
  output logic                         log_ovf,
  output logic                         err
);

  localparam int PW       = $clog2(LOG_DEPTH);
  localparam int MEM_SIZE = 1 << ADR_BITS;
  localparam logic [PW:0] DEPTH_C = (PW+1)'(LOG_DEPTH);

  logic [7:0]  mem_q [MEM_SIZE];
  logic [15:0] log_adr_mem_q [LOG_DEPTH];
  logic [7:0]  log_dat_mem_q [LOG_DEPTH];

  logic [1:0]  tphase_q, tphase_d;
  logic [7:0]  mcyc_q, mcyc_d;
  logic [15:0] cyc_adr_q, cyc_adr_d;
  logic        cyc_rd_q, cyc_rd_d;
  logic        cyc_wr_q, cyc_wr_d;
  logic [7:0]  din_q, din_d;
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PW:0] count_q, count_d;
  logic        ovf_q, ovf_d;
  logic        err_q, err_d;

  logic        t1, t4, commit, full, pop, push_ok, mem_we_cpu, mem_we_init;
  logic [ADR_BITS-1:0] cyc_idx;

  assign t1      = (tphase_q == 2'd0);
  assign t4      = (tphase_q == 2'd3);
  assign cyc_idx = cyc_adr_q[ADR_BITS-1:0];
  assign commit  = t4 && cyc_wr_q;
  assign full    = (count_q == DEPTH_C);
  assign pop     = log_pop && (count_q != '0);
  assign push_ok = commit && (!full || pop);

  // A CPU commit to the same index overrides a same-edge preload.
  assign mem_we_cpu  = commit && !reset;
  assign mem_we_init = init_we && !(mem_we_cpu && (init_adr == cyc_idx));

  always_comb begin
    tphase_d  = tphase_q + 2'd1;
    mcyc_d    = mcyc_q;
    cyc_adr_d = cyc_adr_q;
    cyc_rd_d  = cyc_rd_q;
    cyc_wr_d  = cyc_wr_q;
    din_d     = cyc_rd_q ? din_q : 8'hFF;
    err_d     = err_q;
    if (t4 && (mcyc_q != 8'hFF)) mcyc_d = mcyc_q + 8'd1;
    if (t1) begin
      cyc_adr_d = adr;
      cyc_rd_d  = rd && !wr;
      cyc_wr_d  = wr && !rd;
      if (rd && wr) err_d = 1'b1;
      din_d = (rd && !wr) ? mem_q[adr[ADR_BITS-1:0]] : 8'hFF;
    end
    if (t4) din_d = 8'hFF;
  end

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (push_ok) wptr_d = wptr_q + 1'b1;
    if (pop)     rptr_d = rptr_q + 1'b1;
    if (push_ok && !pop)      count_d = count_q + 1'b1;
    else if (!push_ok && pop) count_d = count_q - 1'b1;
    if (commit && full && !pop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tphase_q  <= 2'd0;
      mcyc_q    <= 8'd0;
      cyc_adr_q <= 16'd0;
      cyc_rd_q  <= 1'b0;
      cyc_wr_q  <= 1'b0;
      din_q     <= 8'hFF;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      tphase_q  <= tphase_d;
      mcyc_q    <= mcyc_d;
      cyc_adr_q <= cyc_adr_d;
      cyc_rd_q  <= cyc_rd_d;
      cyc_wr_q  <= cyc_wr_d;
      din_q     <= din_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      err_q     <= err_d;
    end
  end

  // Storage arrays carry no reset; RAM contents survive reset by design.
  always_ff @(posedge clk) begin
    if (mem_we_cpu)  mem_q[cyc_idx]  <= dout;
    if (mem_we_init) mem_q[init_adr] <= init_data;
    if (push_ok && !reset) begin
      log_adr_mem_q[wptr_q] <= cyc_adr_q;
      log_dat_mem_q[wptr_q] <= dout;
    end
  end

  assign din       = din_q;
  assign tphase    = tphase_q;
  assign mcyc      = mcyc_q;
  assign log_valid = (count_q != '0);
  assign log_adr   = log_adr_mem_q[rptr_q];
  assign log_data  = log_dat_mem_q[rptr_q];
  assign log_count = count_q;
  assign log_ovf   = ovf_q;
  assign err       = err_q;

endmodule
